// File: rtl/ddls_trace_buffer.sv
// ddls_trace_buffer: circular multi-channel DDLS probe trace buffer with value-match trigger and 1-cycle read port
module ddls_trace_buffer #(
  parameter int NUM_CH = 4,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cap_en_i,
  input  logic [NUM_CH*32-1:0] probe_i,
  input  logic                 probe_valid_i,
  input  logic                 arm_i,
  input  logic [NUM_CH-1:0]    trig_mask_i,
  input  logic [31:0]          trig_value_i,
  input  logic                 rd_req_i,
  input  logic [CW-1:0]        rd_ch_i,
  input  logic [AW-1:0]        rd_idx_i,
  output logic                 rd_valid_o,
  output logic [31:0]          rd_data_o,
  output logic                 rd_err_o,
  output logic [1:0]           state_o,
  output logic [AW:0]          count_o,
  output logic [AW-1:0]        trig_idx_o
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_W = (AW+1)'(POST_TRIG);
  localparam logic [CW:0] NUM_CH_W = (CW+1)'(NUM_CH);
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, oldest, rd_addr;
  logic [AW:0] count_q, count_d, post_q, post_d;
  logic rd_valid_q, rd_valid_d, rd_err_q, rd_err_d, acc, hit, rd_ok;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] mem [NUM_CH][DEPTH];
  always_comb begin
    acc = cap_en_i & probe_valid_i & (state_q == ARMED | state_q == POST) & ~arm_i;
    hit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) hit |= trig_mask_i[c] & (probe_i[c*32 +: 32] == trig_value_i);
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d = count_q;
    post_d = post_q;
    trig_ptr_d = trig_ptr_q;
    if (arm_i) begin
      state_d = ARMED;
      wr_ptr_d = '0;
      count_d = '0;
      post_d = '0;
    end else if (acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q == DEPTH_W ? count_q : count_q + 1'b1;
      if (state_q == ARMED && hit) begin
        trig_ptr_d = wr_ptr_q;
        state_d = POST_TRIG == 0 ? DONE : POST;
      end else if (state_q == POST) begin
        post_d = post_q + 1'b1;
        state_d = post_d == POST_W ? DONE : POST;
      end
    end
    oldest = wr_ptr_q - count_q[AW-1:0];
    rd_addr = oldest + rd_idx_i;
    rd_ok = state_q == DONE && {1'b0, rd_idx_i} < count_q && {1'b0, rd_ch_i} < NUM_CH_W;
    rd_valid_d = rd_req_i;
    rd_err_d = rd_req_i & ~rd_ok;
    rd_data_d = rd_req_i && rd_ok ? mem[rd_ch_i][rd_addr] : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      count_q <= '0;
      post_q <= '0;
      trig_ptr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      post_q <= post_d;
      trig_ptr_q <= trig_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc)
      for (int c = 0; c < NUM_CH; c++) mem[c][wr_ptr_q] <= probe_i[c*32 +: 32];
  end
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o = rd_data_q;
  assign rd_err_o = rd_err_q;
  assign state_o = state_q;
  assign count_o = count_q;
  assign trig_idx_o = trig_ptr_q - oldest;
endmodule

// File: tb/tb_ddls_trace_buffer.sv
// tb_ddls_trace_buffer: randomized and directed checks of ddls_trace_buffer against a queue-based trace model
module tb_ddls_trace_buffer;
  localparam int NC = 4;
  localparam int D = 16;
  localparam int P = 8;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic cap_en = 1'b0, cap_en0 = 1'b0, valid = 1'b0, arm = 1'b0, arm0 = 1'b0, rd_req = 1'b0;
  logic [NC*32-1:0] probe = '0;
  logic [NC-1:0] mask = '0;
  logic [31:0] value = '0;
  logic [1:0] rd_ch = '0;
  logic [3:0] rd_idx = '0;
  logic rv, re, rv0, re0;
  logic [31:0] rd, rd0;
  logic [1:0] st, st0;
  logic [4:0] cnt, cnt0;
  logic [3:0] ti, ti0;
  int n_assert = 0, n_fail = 0;
  int m_st = 0, m_trig = 0, m_post = 0;
  logic [NC*32-1:0] hist[$];
  bit e_valid, e_err;
  logic [31:0] e_data;
  always #5 clk = ~clk;
  ddls_trace_buffer #(.NUM_CH(NC), .DEPTH(D), .POST_TRIG(P)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cap_en_i(cap_en), .probe_i(probe), .probe_valid_i(valid),
    .arm_i(arm), .trig_mask_i(mask), .trig_value_i(value), .rd_req_i(rd_req), .rd_ch_i(rd_ch),
    .rd_idx_i(rd_idx), .rd_valid_o(rv), .rd_data_o(rd), .rd_err_o(re), .state_o(st),
    .count_o(cnt), .trig_idx_o(ti)
  );
  ddls_trace_buffer #(.NUM_CH(NC), .DEPTH(D), .POST_TRIG(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .cap_en_i(cap_en0), .probe_i(probe), .probe_valid_i(valid),
    .arm_i(arm0), .trig_mask_i(mask), .trig_value_i(value), .rd_req_i(rd_req), .rd_ch_i(rd_ch),
    .rd_idx_i(rd_idx), .rd_valid_o(rv0), .rd_data_o(rd0), .rd_err_o(re0), .state_o(st0),
    .count_o(cnt0), .trig_idx_o(ti0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit ok, hit;
    e_valid = rd_req;
    ok = m_st == 3 && int'(rd_idx) < hist.size() && int'(rd_ch) < NC;
    e_err = rd_req && !ok;
    e_data = '0;
    if (rd_req && ok) e_data = hist[rd_idx][rd_ch*32 +: 32];
    hit = 1'b0;
    for (int c = 0; c < NC; c++) if (mask[c] && probe[c*32 +: 32] == value) hit = 1'b1;
    if (arm) begin
      m_st = 1;
      hist.delete();
      m_post = 0;
    end else if (cap_en && valid && (m_st == 1 || m_st == 2)) begin
      hist.push_back(probe);
      if (hist.size() > D) begin
        void'(hist.pop_front());
        m_trig--;
      end
      if (m_st == 1 && hit) begin
        m_trig = hist.size() - 1;
        m_st = 2;
        m_post = 0;
      end else if (m_st == 2) begin
        m_post++;
        if (m_post == P) m_st = 3;
      end
    end
    @(posedge clk);
    #1;
    chk("state", 32'(st), m_st);
    chk("count", 32'(cnt), hist.size());
    if (m_st == 3) chk("trig_idx", 32'(ti), m_trig);
    chk("rd_valid", 32'(rv), 32'(e_valid));
    chk("rd_data", rd, e_data);
    chk("rd_err", 32'(re), 32'(e_err));
  endtask
  task automatic read_all();
    valid = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      rd_ch = 2'($urandom_range(0, NC - 1));
      rd_idx = 4'(i);
      tick();
    end
    rd_req = 1'b0;
    tick();
  endtask
  initial begin
    #11;
    chk("rst_state", 32'(st), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_rd_valid", 32'(rv), 0);
    chk("rst_rd_data", rd, 0);
    chk("rst_rd_err", 32'(re), 0);
    #1 rst_ni = 1'b1;
    // pre-trigger history shorter than the buffer
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cap_en = 1'b1;
    mask = 4'b0001;
    value = 32'd5;
    valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      probe = {$urandom, $urandom, $urandom, 32'(i)};
      tick();
    end
    valid = 1'b0;
    rd_req = 1'b1;
    rd_ch = 2'd0;
    rd_idx = 4'd0;
    tick();
    chk("A_idx0", rd, 32'd1);
    rd_idx = 4'd12;
    tick();
    chk("A_idx12", rd, 32'd13);
    chk("A_count", 32'(cnt), 32'd13);
    chk("A_trig_idx", 32'(ti), 32'd4);
    read_all();
    // wrapped buffer
    arm = 1'b1;
    tick();
    arm = 1'b0;
    value = 32'd130;
    valid = 1'b1;
    for (int i = 100; i < 140; i++) begin
      probe = {$urandom, $urandom, $urandom, 32'(i)};
      tick();
    end
    valid = 1'b0;
    rd_req = 1'b1;
    rd_ch = 2'd0;
    rd_idx = 4'd0;
    tick();
    chk("B_oldest", rd, 32'd123);
    rd_idx = 4'd15;
    tick();
    chk("B_idx15", rd, 32'd138);
    chk("B_count", 32'(cnt), 32'd16);
    chk("B_trig_idx", 32'(ti), 32'd7);
    read_all();
    // only masked channels participate
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mask = 4'b0100;
    value = 32'hDEAD_BEEF;
    valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      probe = {$urandom & 32'h0FFF_FFFF, $urandom & 32'h0FFF_FFFF, $urandom & 32'h0FFF_FFFF, $urandom & 32'h0FFF_FFFF};
      if (i == 1) probe[31:0] = value;
      if (i == 4) probe[95:64] = value;
      tick();
      if (i == 3) chk("C_ch0_ignored", 32'(st), 32'd1);
    end
    chk("C_done", 32'(st), 32'd3);
    chk("C_trig_idx", 32'(ti), 32'd4);
    read_all();
    // arm beats a same-cycle matching sample
    mask = 4'b0001;
    value = 32'd7;
    probe = {$urandom, $urandom, $urandom, 32'd7};
    valid = 1'b1;
    arm = 1'b1;
    tick();
    chk("D_armed", 32'(st), 32'd1);
    chk("D_count", 32'(cnt), 32'd0);
    arm = 1'b0;
    tick();
    chk("D_post", 32'(st), 32'd2);
    chk("D_count1", 32'(cnt), 32'd1);
    // randomized traffic
    for (int r = 0; r < 800; r++) begin
      if (r % 100 == 0) begin
        mask = 4'($urandom);
        value = $urandom_range(0, 15);
      end
      arm = $urandom_range(0, 39) == 0;
      cap_en = $urandom_range(0, 4) != 0;
      valid = $urandom_range(0, 2) != 0;
      probe = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)), 32'($urandom_range(0, 15))};
      rd_req = $urandom_range(0, 1) == 1;
      rd_ch = 2'($urandom);
      rd_idx = 4'($urandom);
      tick();
    end
    // asynchronous reset during POST
    arm = 1'b1;
    rd_req = 1'b0;
    cap_en = 1'b1;
    tick();
    arm = 1'b0;
    mask = 4'b0001;
    value = 32'd0;
    valid = 1'b1;
    probe = '0;
    tick();
    probe[31:0] = 32'd1;
    tick();
    chk("R_in_post", 32'(st), 32'd2);
    valid = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    chk("R_state", 32'(st), 0);
    chk("R_count", 32'(cnt), 0);
    chk("R_rd_valid", 32'(rv), 0);
    m_st = 0;
    hist.delete();
    #2 rst_ni = 1'b1;
    rd_req = 1'b1;
    rd_idx = 4'd0;
    tick();
    chk("R_read_err", 32'(re), 32'd1);
    rd_req = 1'b0;
    cap_en = 1'b0;
    // zero post-trigger depth build
    arm0 = 1'b1;
    tick();
    arm0 = 1'b0;
    cap_en0 = 1'b1;
    mask = 4'b0001;
    value = 32'd3;
    valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      probe = {$urandom & 32'h0FFF_FFFF, $urandom, $urandom, 32'(i)};
      tick();
      if (i == 2) chk("Z_armed", 32'(st0), 32'd1);
    end
    chk("Z_done", 32'(st0), 32'd3);
    chk("Z_count", 32'(cnt0), 32'd3);
    chk("Z_trig_idx", 32'(ti0), 32'd2);
    valid = 1'b0;
    rd_req = 1'b1;
    rd_ch = 2'd0;
    rd_idx = 4'd3;
    tick();
    chk("Z_oob_valid", 32'(rv0), 32'd1);
    chk("Z_oob_err", 32'(re0), 32'd1);
    chk("Z_oob_data", rd0, 32'd0);
    rd_idx = 4'd2;
    tick();
    chk("Z_trig_err", 32'(re0), 32'd0);
    chk("Z_trig_data", rd0, 32'd3);
    rd_req = 1'b0;
    tick();
    chk("Z_idle_valid", 32'(rv0), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/ddls_trace_buffer.md
Name: ddls_trace_buffer

Overview:
- Parametrised successor to the core top's flat DDLS probe outputs.
- Captures NUM_CH 32-bit DDLS probe channels (e.g. pc_id, regfile_wdata, jump_target) into a circular on-chip trace buffer with a value-match trigger and configurable post-trigger depth.
- Sits beside the RISC-V core top, gated by the same clk_out_riscv_en-style capture enable.
- Frozen contents are read back through a 1-cycle-latency read port feeding the scan-out path.

Parameters:
- NUM_CH, 4, number of 32-bit probe channels (1..9).
- DEPTH, 16, samples per channel; power of 2, >= 4.
- POST_TRIG, 8, samples stored after the trigger sample; 0 <= POST_TRIG < DEPTH.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- cap_en_i  in  1  capture enable; when low, samples are ignored and state is held.
- probe_i  in  NUM_CH x 32  DDLS probe channels.
- probe_valid_i  in  1  probe sample valid this cycle.
- arm_i  in  1  single-cycle pulse: clear buffer and start capture.
- trig_mask_i  in  NUM_CH  channels participating in the trigger compare.
- trig_value_i  in  32  trigger compare value.
- rd_req_i  in  1  read request.
- rd_ch_i  in  $clog2(NUM_CH) (min 1)  channel to read.
- rd_idx_i  in  $clog2(DEPTH)  sample index; 0 = oldest stored sample.
- rd_valid_o  out  1  read data valid; pulses 1 cycle after rd_req_i.
- rd_data_o  out  32  read data.
- rd_err_o  out  1  read rejected; qualified by rd_valid_o.
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- count_o  out  $clog2(DEPTH)+1  stored samples, saturating at DEPTH.
- trig_idx_o  out  $clog2(DEPTH)  index of the trigger sample relative to the oldest; valid in DONE.

Behaviour:
- Reset (async, any state, mid-capture included): state IDLE; write pointer, count, post-counter and trigger index all 0; rd_valid_o 0, rd_data_o 0, rd_err_o 0. Buffer RAM contents are not reset.
- Sample accepted = cap_en_i & probe_valid_i & state in {ARMED, POST} & !arm_i.
- Each accepted sample writes all NUM_CH channels at wr_ptr; then wr_ptr+1 (wraps modulo DEPTH); count+1, saturating at DEPTH.
- arm_i in any state: next state ARMED; wr_ptr, count and post-counter cleared. arm_i has priority over a same-cycle sample and trigger; that sample is dropped.
- Trigger hit = accepted sample in ARMED & OR over ch of (trig_mask_i[ch] & probe_i[ch] == trig_value_i). trig_mask_i == 0 never triggers.
- ARMED -> POST on hit. The trigger sample is stored and its slot recorded as trig_ptr. If POST_TRIG == 0, go directly to DONE instead.
- POST: each accepted sample increments post-counter; after the POST_TRIG-th sample, go to DONE. Further hits in POST are ignored.
- DONE: capture frozen; only arm_i leaves DONE. IDLE: holds until arm_i.
- Oldest slot = (wr_ptr - count) mod DEPTH. trig_idx_o = (trig_ptr - oldest) mod DEPTH.
- Fewer than DEPTH pre-trigger samples is legal: count < DEPTH and trig_idx_o equals the number of pre-trigger samples.
- Read port, latency 1 cycle:
  - rd_valid_o = registered rd_req_i.
  - Request accepted only in DONE with rd_idx_i < count and rd_ch_i < NUM_CH. Then rd_data_o = buffer[rd_ch_i][(oldest + rd_idx_i) mod DEPTH] and rd_err_o = 0.
  - Otherwise rd_data_o = 0 and rd_err_o = 1.
  - Back-to-back requests are allowed, one per cycle.
  - rd_data_o and rd_err_o return to 0 in cycles without a request.
- Reads do not alter capture state. Read and arm in the same cycle: the read is evaluated against the pre-arm state.

Test Plan:
- Reset mid-POST -> state_o 0, count_o 0, rd_valid_o 0; a read the next cycle -> rd_err_o 1.
- Arm; feed ch0 = 1..20 with mask 1, value 5 -> DONE after sample 13; count_o 13; trig_idx_o 4; read idx0 = 1, idx12 = 13.
- Arm; ch0 = 100..139, trigger on 130 -> buffer wraps; count_o 16; oldest read = 123; trig_idx_o 7; idx15 = 138.
- Trigger on ch2 only, mask 4'b0100; ch0 also carries the trigger value earlier -> ch0 match ignored; trigger fires on the ch2 match.
- arm_i in the same cycle as a matching sample -> sample dropped, state ARMED, count_o 0; the next match triggers.
- POST_TRIG = 0 build: match -> DONE the next cycle; trig_idx_o = count_o - 1; rd_idx_i = count_o -> rd_err_o 1.
